regfile_sb: RTL and testbench



---
 rtl/lemon_rf_pkg.sv | 12 +
 rtl/regfile_sb_if.sv | 36 +++
 rtl/regfile_sb_scoreboard.sv | 72 +++++++
 rtl/regfile_sb.sv | 130 +++++++++++++
 tb/tb_regfile_sb.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/lemon_rf_pkg.sv
// Shared constants and helpers for the LemonPC integer register file.
// Imported by the register file top and its pending-write scoreboard.
package lemon_rf_pkg;

    localparam int ZERO_IDX = 0;

    // Width of one packed change report: {addr, old value, new value}.
    function automatic int dbg_rec_width(input int addr_width, input int data_width);
        return addr_width + 2 * data_width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read, write, reserve and debug trace.
// The master drives indices, strobes and data; the slave (register file) returns the results.
interface regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
);
    logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;
    logic [NUM_READ-1:0]             rd_ready;
    logic [NUM_WRITE-1:0]            wr_en;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
    logic                            rsv_en;
    logic [ADDR_WIDTH-1:0]           rsv_addr;
    logic                            rsv_ok;
    logic [ADDR_WIDTH:0]             pending_cnt;
    logic [NUM_WRITE-1:0]            dbg_valid;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] dbg_addr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] dbg_old;
    logic [NUM_WRITE*DATA_WIDTH-1:0] dbg_new;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_ready, rsv_ok, pending_cnt,
        input  dbg_valid, dbg_addr, dbg_old, dbg_new
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_ready, rsv_ok, pending_cnt,
        output dbg_valid, dbg_addr, dbg_old, dbg_new
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, reserve/clear arbitration
// and a registered population count of the pending bits.
module rf_scoreboard
    import lemon_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WRITE  = 1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WRITE-1:0]            wr_eff_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                            rsv_en_i,
    input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
    output logic [(1<<ADDR_WIDTH)-1:0]      pending_o,
    output logic                            rsv_ok_o,
    output logic [ADDR_WIDTH:0]             pending_cnt_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_IDX);

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsv_zero;
    logic             clr_hit;

    assign rsv_zero = ZERO_REG && (rsv_addr_i == ZIDX);

    always_comb begin
        clr_hit = 1'b0;
        for (int i = 0; i < NUM_WRITE; i++) begin
            if (wr_eff_i[i] && (wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == rsv_addr_i))
                clr_hit = 1'b1;
        end
    end

    // A writeback landing on the same register frees it for a new reservation this cycle.
    assign rsv_ok_o = rsv_en_i && (rsv_zero || !pending_q[rsv_addr_i] || clr_hit);

    // Clears are applied first so a same-cycle reserve of the same register wins.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_WRITE; i++) begin
            if (wr_eff_i[i])
                pending_d[wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        end
        if (rsv_ok_o && !rsv_zero)
            pending_d[rsv_addr_i] = 1'b1;
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < DEPTH; r++)
            cnt_d = cnt_d + CW'(pending_d[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o     = pending_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with pending-write scoreboard, optional same-cycle
// bypass and a registered change-report port, between decode and writeback.
module regfile_sb
    import lemon_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave bus
);
    localparam int AW    = ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int DBG_W = dbg_rec_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);

    logic [DW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_addr_a [NUM_WRITE];
    logic [DW-1:0]        wr_data_a [NUM_WRITE];
    logic [NUM_WRITE-1:0] wr_eff;
    logic [DEPTH-1:0]     pending;

    // Write arbitration: the highest-index port targeting an address is the only effective one.
    for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wr
        logic shadowed;

        assign wr_addr_a[gi] = bus.wr_addr[gi*AW +: AW];
        assign wr_data_a[gi] = bus.wr_data[gi*DW +: DW];

        always_comb begin
            shadowed = 1'b0;
            for (int j = gi + 1; j < NUM_WRITE; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == wr_addr_a[gi]))
                    shadowed = 1'b1;
            end
        end

        assign wr_eff[gi] = bus.wr_en[gi] && !(ZERO_REG && (wr_addr_a[gi] == ZIDX)) && !shadowed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                mem_q[r] <= '0;
        end else begin
            for (int i = 0; i < NUM_WRITE; i++) begin
                if (wr_eff[i])
                    mem_q[wr_addr_a[i]] <= wr_data_a[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ready;

        assign addr = bus.rd_addr[gi*AW +: AW];

        always_comb begin
            data  = mem_q[addr];
            ready = !pending[addr];
            if (BYPASS) begin
                for (int i = 0; i < NUM_WRITE; i++) begin
                    if (wr_eff[i] && (wr_addr_a[i] == addr)) begin
                        data  = wr_data_a[i];
                        ready = 1'b1;
                    end
                end
            end
            if (ZERO_REG && (addr == ZIDX)) begin
                data  = '0;
                ready = 1'b1;
            end
        end

        assign bus.rd_data[gi*DW +: DW] = data;
        assign bus.rd_ready[gi]         = ready;
    end

    // Change report: only effective writes that actually alter the stored value.
    for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_dbg
        logic [DW-1:0]    old_val;
        logic             fire;
        logic             valid_q;
        logic [DBG_W-1:0] rec_q;

        assign old_val = mem_q[wr_addr_a[gi]];
        assign fire    = wr_eff[gi] && (wr_data_a[gi] != old_val);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                rec_q   <= '0;
            end else begin
                valid_q <= fire;
                if (fire)
                    rec_q <= {wr_addr_a[gi], old_val, wr_data_a[gi]};
            end
        end

        assign bus.dbg_valid[gi]         = valid_q;
        assign bus.dbg_addr[gi*AW +: AW] = rec_q[DBG_W-1 -: AW];
        assign bus.dbg_old[gi*DW +: DW]  = rec_q[2*DW-1 -: DW];
        assign bus.dbg_new[gi*DW +: DW]  = rec_q[DW-1:0];
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_eff_i      (wr_eff),
        .wr_addr_i     (bus.wr_addr),
        .rsv_en_i      (bus.rsv_en),
        .rsv_addr_i    (bus.rsv_addr),
        .pending_o     (pending),
        .rsv_ok_o      (bus.rsv_ok),
        .pending_cnt_o (bus.pending_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations tagged with
// the cycle they apply to; a negedge monitor pops and compares them against the DUT.
module tb_regfile_sb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    localparam int K_RDATA = 0;
    localparam int K_RRDY  = 1;
    localparam int K_RSVOK = 2;
    localparam int K_PCNT  = 3;
    localparam int K_DV    = 4;
    localparam int K_DADDR = 5;
    localparam int K_DOLD  = 6;
    localparam int K_DNEW  = 7;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  kind;
        logic [3:0]  idx;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    chk_t exp_q[$];

    regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();

    regfile_sb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_READ   (NR),
        .NUM_WRITE  (NW),
        .BYPASS     (1'b1),
        .ZERO_REG   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input logic [3:0] k);
        case (int'(k))
            K_RDATA: return "rd_data";
            K_RRDY:  return "rd_ready";
            K_RSVOK: return "rsv_ok";
            K_PCNT:  return "pending_cnt";
            K_DV:    return "dbg_valid";
            K_DADDR: return "dbg_addr";
            K_DOLD:  return "dbg_old";
            K_DNEW:  return "dbg_new";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input logic [3:0] k, input int i);
        case (int'(k))
            K_RDATA: return bus.rd_data[i*DW +: DW];
            K_RRDY:  return 32'(bus.rd_ready[i]);
            K_RSVOK: return 32'(bus.rsv_ok);
            K_PCNT:  return 32'(bus.pending_cnt);
            K_DV:    return 32'(bus.dbg_valid);
            K_DADDR: return 32'(bus.dbg_addr[i*AW +: AW]);
            K_DOLD:  return bus.dbg_old[i*DW +: DW];
            K_DNEW:  return bus.dbg_new[i*DW +: DW];
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, half a period after the edge.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            c   = exp_q.pop_front();
            act = actual(c.kind, int'(c.idx));
            n_vec++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s[%0d] cyc %0d: got 0x%0h, want 0x%0h",
                         kname(c.kind), c.idx, cyc, act, c.exp);
            end else begin
                $display("check %s[%0d] cyc %0d: 0x%0h ok", kname(c.kind), c.idx, cyc, act);
            end
        end
    end

    function automatic void expect_at(input int dc, input int k, input int i, input logic [31:0] e);
        chk_t c;
        c.cyc  = 32'(cyc + dc);
        c.kind = 4'(k);
        c.idx  = 4'(i);
        c.exp  = e;
        exp_q.push_back(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[p]           = 1'b1;
        bus.wr_addr[p*AW +: AW] = a;
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        bus.rd_addr = '0;
        step();
        step();
        // Reset state
        rd(0, 5'd4); rd(1, 5'd31);
        expect_at(0, K_RDATA, 0, 0); expect_at(0, K_RDATA, 1, 0);
        expect_at(0, K_RRDY, 0, 1);  expect_at(0, K_RRDY, 1, 1);
        expect_at(0, K_PCNT, 0, 0);  expect_at(0, K_DV, 0, 0);
        step();
        rst_n = 1'b1;

        // Fill some state, then reset asynchronously and see it cleared
        step(); idle();
        wr(0, 5'd1, 32'hA5A5_0001); wr(1, 5'd2, 32'h5A5A_0002); rsv(5'd9); rd(0, 5'd1);
        expect_at(0, K_RDATA, 0, 32'hA5A5_0001); expect_at(0, K_RSVOK, 0, 1);
        expect_at(1, K_DV, 0, 3); expect_at(1, K_DADDR, 1, 2); expect_at(1, K_DNEW, 1, 32'h5A5A_0002);
        step(); idle(); rd(0, 5'd1); rd(1, 5'd2);
        expect_at(0, K_RDATA, 0, 32'hA5A5_0001); expect_at(0, K_RDATA, 1, 32'h5A5A_0002);
        expect_at(0, K_PCNT, 0, 1);
        step(); idle(); rst_n = 1'b0; rd(0, 5'd1); rd(1, 5'd9);
        expect_at(0, K_RDATA, 0, 0); expect_at(0, K_RRDY, 1, 1);
        expect_at(0, K_PCNT, 0, 0);  expect_at(0, K_DV, 0, 0);
        step(); rst_n = 1'b1;

        // Bypassed write of x5, then a same-value rewrite that must not report
        step(); idle(); wr(0, 5'd5, 32'hDEAD_BEEF); rd(0, 5'd5);
        expect_at(0, K_RDATA, 0, 32'hDEAD_BEEF); expect_at(0, K_RRDY, 0, 1);
        expect_at(1, K_DV, 0, 1); expect_at(1, K_DADDR, 0, 5);
        expect_at(1, K_DOLD, 0, 0); expect_at(1, K_DNEW, 0, 32'hDEAD_BEEF);
        step(); idle(); wr(0, 5'd5, 32'hDEAD_BEEF); rd(0, 5'd5);
        expect_at(0, K_RDATA, 0, 32'hDEAD_BEEF); expect_at(1, K_DV, 0, 0);

        // Register zero: write ignored, reserve accepted without state change
        step(); idle(); wr(0, 5'd0, 32'h1234); rsv(5'd0); rd(0, 5'd0);
        expect_at(0, K_RDATA, 0, 0); expect_at(0, K_RRDY, 0, 1); expect_at(0, K_RSVOK, 0, 1);
        expect_at(1, K_DV, 0, 0); expect_at(1, K_PCNT, 0, 0);

        // Reserve x7, double reserve refused, writeback with simultaneous re-reserve
        step(); idle(); rsv(5'd7); rd(0, 5'd0);
        expect_at(0, K_RSVOK, 0, 1);
        step(); idle(); rsv(5'd7); rd(0, 5'd7);
        expect_at(0, K_RRDY, 0, 0); expect_at(0, K_PCNT, 0, 1); expect_at(0, K_RSVOK, 0, 0);
        step(); idle(); rsv(5'd7); wr(0, 5'd7, 32'd9); rd(0, 5'd7);
        expect_at(0, K_RSVOK, 0, 1); expect_at(0, K_RDATA, 0, 9);
        expect_at(0, K_RRDY, 0, 1);  expect_at(0, K_PCNT, 0, 1);
        expect_at(1, K_DV, 0, 1); expect_at(1, K_DADDR, 0, 7); expect_at(1, K_DNEW, 0, 9);
        step(); idle(); rd(0, 5'd7);
        expect_at(0, K_RDATA, 0, 9); expect_at(0, K_RRDY, 0, 0); expect_at(0, K_PCNT, 0, 1);

        // Both write ports hit x3: port 1 wins, only its report fires
        step(); idle(); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rd(1, 5'd3);
        expect_at(0, K_RDATA, 1, 32'h22);
        expect_at(1, K_DV, 0, 2); expect_at(1, K_DADDR, 1, 3);
        expect_at(1, K_DOLD, 1, 0); expect_at(1, K_DNEW, 1, 32'h22);
        step(); idle(); rd(1, 5'd3);
        expect_at(0, K_RDATA, 1, 32'h22);

        // Four pending registers, then mid-cycle asynchronous reset
        step(); idle(); rsv(5'd10);
        expect_at(0, K_RSVOK, 0, 1);
        step(); idle(); rsv(5'd11);
        step(); idle(); rsv(5'd12);
        step(); idle(); rd(0, 5'd7);
        expect_at(0, K_PCNT, 0, 4); expect_at(0, K_RRDY, 0, 0);
        step(); idle(); rsv(5'd13); rd(0, 5'd7);
        #1 rst_n = 1'b0;
        expect_at(0, K_PCNT, 0, 0); expect_at(0, K_RRDY, 0, 1); expect_at(0, K_RDATA, 0, 0);
        step(); idle(); rst_n = 1'b1; rd(1, 5'd13);
        expect_at(0, K_PCNT, 0, 0); expect_at(0, K_RRDY, 1, 1);

        step();
        step();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
